// File: rtl/uart_buffered.sv
// Buffered UART: TX and RX FIFOs around serial framers with a runtime baud divisor.
// Define UART_BUFFERED_PARITY_EN to add an even-parity bit to every frame.
module uart_buffered #(
  parameter int DATA_BITS  = 8,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [DIV_W-1:0]     divisor,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_parity_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd4;
`ifdef UART_BUFFERED_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic [DIV_W-1:0] DIV_ONE = 1;
  localparam logic [PTR_W:0] PTR_ONE = 1;

  logic [DATA_BITS-1:0] r_txMem [FIFO_DEPTH];
  logic [PTR_W:0]       r_txWr, r_txRd;
  logic [PTR_W:0]       w_txRdNext;
  logic                 w_txEmpty, w_txFull, w_txPush, w_txPop, w_txTick;
  logic [2:0]           r_txState;
  logic [DIV_W-1:0]     r_txCnt, r_txDiv;
  logic [DATA_BITS-1:0] r_txShift;
  logic [2:0]           r_txBit;
  logic                 r_tx;
`ifdef UART_BUFFERED_PARITY_EN
  logic                 r_txPar;
`endif

  assign w_txEmpty  = (r_txWr == r_txRd);
  assign w_txFull   = (r_txWr[PTR_W] != r_txRd[PTR_W]) &&
                      (r_txWr[PTR_W-1:0] == r_txRd[PTR_W-1:0]);
  assign w_txPush   = tx_valid && !w_txFull;
  assign w_txRdNext = r_txRd + PTR_ONE;
  assign w_txTick   = (r_txCnt == '0);
  // The in-flight byte stays in the FIFO until its stop bit ends.
  assign w_txPop    = (r_txState == S_STOP) && w_txTick;
  assign tx_ready   = !w_txFull;
  assign tx         = r_tx;
  assign tx_busy    = !w_txEmpty || (r_txState != S_IDLE);

  always_ff @(posedge clk) begin
    if (w_txPush) r_txMem[r_txWr[PTR_W-1:0]] <= tx_data;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_txWr <= '0;
      r_txRd <= '0;
    end else begin
      if (w_txPush) r_txWr <= r_txWr + PTR_ONE;
      if (w_txPop)  r_txRd <= w_txRdNext;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_txState <= S_IDLE;
      r_txCnt   <= '0;
      r_txDiv   <= '0;
      r_txShift <= '0;
      r_txBit   <= '0;
      r_tx      <= 1'b1;
`ifdef UART_BUFFERED_PARITY_EN
      r_txPar   <= 1'b0;
`endif
    end else begin
      case (r_txState)
        S_IDLE: if (!w_txEmpty) begin
          r_txState <= S_START;
          r_tx      <= 1'b0;
          r_txDiv   <= divisor;
          r_txCnt   <= divisor - DIV_ONE;
          r_txShift <= r_txMem[r_txRd[PTR_W-1:0]];
        end
        S_START: if (w_txTick) begin
          r_txState <= S_DATA;
          r_tx      <= r_txShift[0];
          r_txCnt   <= r_txDiv - DIV_ONE;
          r_txBit   <= '0;
`ifdef UART_BUFFERED_PARITY_EN
          r_txPar   <= ^r_txShift;
`endif
        end else r_txCnt <= r_txCnt - DIV_ONE;
        S_DATA: if (w_txTick) begin
          r_txCnt <= r_txDiv - DIV_ONE;
          if (r_txBit == LAST_BIT) begin
`ifdef UART_BUFFERED_PARITY_EN
            r_txState <= S_PARITY;
            r_tx      <= r_txPar;
`else
            r_txState <= S_STOP;
            r_tx      <= 1'b1;
`endif
          end else begin
            r_txBit   <= r_txBit + 3'd1;
            r_tx      <= r_txShift[1];
            r_txShift <= r_txShift >> 1;
          end
        end else r_txCnt <= r_txCnt - DIV_ONE;
`ifdef UART_BUFFERED_PARITY_EN
        S_PARITY: if (w_txTick) begin
          r_txState <= S_STOP;
          r_tx      <= 1'b1;
          r_txCnt   <= r_txDiv - DIV_ONE;
        end else r_txCnt <= r_txCnt - DIV_ONE;
`endif
        S_STOP: if (w_txTick) begin
          // Chain straight into the next queued byte so frames carry no idle gap.
          if (w_txRdNext != r_txWr) begin
            r_txState <= S_START;
            r_tx      <= 1'b0;
            r_txDiv   <= divisor;
            r_txCnt   <= divisor - DIV_ONE;
            r_txShift <= r_txMem[w_txRdNext[PTR_W-1:0]];
          end else begin
            r_txState <= S_IDLE;
          end
        end else r_txCnt <= r_txCnt - DIV_ONE;
        default: begin
          r_txState <= S_IDLE;
          r_tx      <= 1'b1;
        end
      endcase
    end
  end

  logic                 r_rxSync1, r_rxSync2, r_rxPrev;
  logic [2:0]           r_rxState;
  logic [DIV_W-1:0]     r_rxCnt, r_rxDiv;
  logic [DATA_BITS-1:0] r_rxShift;
  logic [2:0]           r_rxBit;
  logic                 r_frameErr, r_overrun;
  logic                 w_rxFall, w_rxTick, w_rxStopTick, w_rxGood, w_rxPush, w_rxPop;
  logic [DATA_BITS-1:0] r_rxMem [FIFO_DEPTH];
  logic [PTR_W:0]       r_rxWr, r_rxRd;
  logic                 w_rxEmpty, w_rxFull;
`ifdef UART_BUFFERED_PARITY_EN
  logic                 r_rxParBad, r_parErr;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rxSync1 <= 1'b1;
      r_rxSync2 <= 1'b1;
      r_rxPrev  <= 1'b1;
    end else begin
      r_rxSync1 <= rx;
      r_rxSync2 <= r_rxSync1;
      r_rxPrev  <= r_rxSync2;
    end
  end

  assign w_rxFall     = r_rxPrev && !r_rxSync2;
  assign w_rxTick     = (r_rxCnt == '0);
  assign w_rxStopTick = (r_rxState == S_STOP) && w_rxTick;
`ifdef UART_BUFFERED_PARITY_EN
  assign w_rxGood     = w_rxStopTick && r_rxSync2 && !r_rxParBad;
`else
  assign w_rxGood     = w_rxStopTick && r_rxSync2;
`endif
  assign w_rxEmpty    = (r_rxWr == r_rxRd);
  assign w_rxFull     = (r_rxWr[PTR_W] != r_rxRd[PTR_W]) &&
                        (r_rxWr[PTR_W-1:0] == r_rxRd[PTR_W-1:0]);
  assign w_rxPop      = !w_rxEmpty && rx_ready;
  assign w_rxPush     = w_rxGood && (!w_rxFull || w_rxPop);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rxState <= S_IDLE;
      r_rxCnt   <= '0;
      r_rxDiv   <= '0;
      r_rxShift <= '0;
      r_rxBit   <= '0;
`ifdef UART_BUFFERED_PARITY_EN
      r_rxParBad <= 1'b0;
`endif
    end else begin
      case (r_rxState)
        S_IDLE: if (w_rxFall) begin
          r_rxState <= S_START;
          r_rxDiv   <= divisor;
          r_rxCnt   <= (divisor >> 1) - DIV_ONE;
        end
        S_START: if (w_rxTick) begin
          r_rxState <= r_rxSync2 ? S_IDLE : S_DATA;
          r_rxCnt   <= r_rxDiv - DIV_ONE;
          r_rxBit   <= '0;
        end else r_rxCnt <= r_rxCnt - DIV_ONE;
        S_DATA: if (w_rxTick) begin
          r_rxShift <= {r_rxSync2, r_rxShift[DATA_BITS-1:1]};
          r_rxCnt   <= r_rxDiv - DIV_ONE;
          if (r_rxBit == LAST_BIT) begin
`ifdef UART_BUFFERED_PARITY_EN
            r_rxState <= S_PARITY;
`else
            r_rxState <= S_STOP;
`endif
          end else r_rxBit <= r_rxBit + 3'd1;
        end else r_rxCnt <= r_rxCnt - DIV_ONE;
`ifdef UART_BUFFERED_PARITY_EN
        S_PARITY: if (w_rxTick) begin
          r_rxParBad <= (r_rxSync2 != ^r_rxShift);
          r_rxState  <= S_STOP;
          r_rxCnt    <= r_rxDiv - DIV_ONE;
        end else r_rxCnt <= r_rxCnt - DIV_ONE;
`endif
        S_STOP: if (w_rxTick) r_rxState <= S_IDLE;
                else r_rxCnt <= r_rxCnt - DIV_ONE;
        default: r_rxState <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_frameErr <= 1'b0;
      r_overrun  <= 1'b0;
`ifdef UART_BUFFERED_PARITY_EN
      r_parErr   <= 1'b0;
`endif
    end else begin
      r_frameErr <= w_rxStopTick && !r_rxSync2;
      r_overrun  <= w_rxGood && w_rxFull && !w_rxPop;
`ifdef UART_BUFFERED_PARITY_EN
      r_parErr   <= (r_rxState == S_PARITY) && w_rxTick && (r_rxSync2 != ^r_rxShift);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (w_rxPush) r_rxMem[r_rxWr[PTR_W-1:0]] <= r_rxShift;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rxWr <= '0;
      r_rxRd <= '0;
    end else begin
      if (w_rxPush) r_rxWr <= r_rxWr + PTR_ONE;
      if (w_rxPop)  r_rxRd <= r_rxRd + PTR_ONE;
    end
  end

  assign rx_valid     = !w_rxEmpty;
  assign rx_data      = w_rxEmpty ? '0 : r_rxMem[r_rxRd[PTR_W-1:0]];
  assign rx_frame_err = r_frameErr;
  assign rx_overrun   = r_overrun;
`ifdef UART_BUFFERED_PARITY_EN
  assign rx_parity_err = r_parErr;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_buffered.sv
// Self-checking bench for uart_buffered: TX framing, FIFO limits, RX decoding and errors.
`timescale 1ns/1ps
module tb_uart_buffered;
  localparam int DB    = 8;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
`ifdef UART_BUFFERED_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME = DB + PB + 2;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic [DW-1:0] divisor = 16;
  logic [DB-1:0] txData = '0;
  logic          txValid = 1'b0;
  logic          txReady, txLine, txBusy;
  logic          rxDrive = 1'b1;
  logic          loopback = 1'b0;
  logic          rxLine;
  logic [DB-1:0] rxData;
  logic          rxValid;
  logic          rxReady = 1'b0;
  logic          rxFrameErr, rxOverrun, rxParityErr;

  int checks = 0;
  int failures = 0;
  int frameErrSeen = 0;
  int overrunSeen = 0;
  int parErrSeen = 0;

  assign rxLine = loopback ? txLine : rxDrive;

  uart_buffered #(.DATA_BITS(DB), .DIV_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .nrst(nrst), .divisor(divisor),
    .tx_data(txData), .tx_valid(txValid), .tx_ready(txReady),
    .tx(txLine), .tx_busy(txBusy),
    .rx(rxLine), .rx_data(rxData), .rx_valid(rxValid), .rx_ready(rxReady),
    .rx_frame_err(rxFrameErr), .rx_overrun(rxOverrun), .rx_parity_err(rxParityErr)
  );

  always #5 clk = ~clk;

  // Count high cycles of each error output; a one-cycle pulse adds exactly one.
  always @(negedge clk) begin
    if (nrst) begin
      if (rxFrameErr === 1'b1) frameErrSeen++;
      if (rxOverrun === 1'b1) overrunSeen++;
      if (rxParityErr === 1'b1) parErrSeen++;
    end
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected line levels for one frame, index 0 = start bit.
  function automatic logic [FRAME-1:0] frameOf(input logic [DB-1:0] b);
    logic [FRAME-1:0] f;
    f = '0;
    f[DB:1] = b;
    if (PB == 1) f[DB+1] = ^b;
    f[FRAME-1] = 1'b1;
    return f;
  endfunction

  task automatic writeTx(input logic [DB-1:0] b);
    txData = b;
    txValid = 1'b1;
    @(negedge clk);
    txValid = 1'b0;
  endtask

  task automatic popRx();
    rxReady = 1'b1;
    @(negedge clk);
    rxReady = 1'b0;
  endtask

  // Waits up to maxWait cycles for a start bit, then records each bit and
  // requires it to hold for bitDiv cycles with tx_busy high throughout.
  task automatic captureTxFrame(input int bitDiv, input int maxWait, input int newDiv,
                                output logic [FRAME-1:0] raw, output bit ok);
    int w;
    logic v;
    ok = 1'b1;
    raw = '0;
    w = 0;
    while (txLine !== 1'b0 && w < maxWait) begin
      @(negedge clk);
      w++;
    end
    if (txLine !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    divisor = DW'(newDiv);
    for (int k = 0; k < FRAME; k++) begin
      v = txLine;
      raw[k] = v;
      for (int c = 0; c < bitDiv; c++) begin
        if (txLine !== v || txBusy !== 1'b1) ok = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  task automatic driveRxFrame(input logic [DB-1:0] b, input int d, input logic stopBit,
                              input logic parFlip);
    rxDrive = 1'b0;
    repeat (d) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rxDrive = b[i];
      repeat (d) @(negedge clk);
    end
    if (PB == 1) begin
      rxDrive = (^b) ^ parFlip;
      repeat (d) @(negedge clk);
    end
    rxDrive = stopBit;
    repeat (d) @(negedge clk);
    rxDrive = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (txLine !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx got=%b want=1", txLine); end
    checks++; if (txReady !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx_ready got=%b want=1", txReady); end
    checks++; if (txBusy !== 1'b0) begin failures++; $display("[TB] FAIL reset_tx_busy got=%b want=0", txBusy); end
    checks++; if (rxValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rx_valid got=%b want=0", rxValid); end
    checks++; if (rxData !== '0) begin failures++; $display("[TB] FAIL reset_rx_data got=%h want=0", rxData); end
    checks++; if ({rxFrameErr, rxOverrun, rxParityErr} !== 3'b000) begin
      failures++; $display("[TB] FAIL reset_err_pulses got=%b want=000", {rxFrameErr, rxOverrun, rxParityErr});
    end
    nrst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tx_frame();
    logic [FRAME-1:0] raw;
    bit ok;
    divisor = 16;
    writeTx(8'hA5);
    captureTxFrame(16, 2, 16, raw, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL tx_a5_timing got=%0d want=1", ok); end
    checks++; if (raw !== frameOf(8'hA5)) begin
      failures++; $display("[TB] FAIL tx_a5_bits got=%b want=%b", raw, frameOf(8'hA5));
    end
    checks++; if (txBusy !== 1'b0) begin failures++; $display("[TB] FAIL tx_a5_busy_end got=%b want=0", txBusy); end
  endtask

  // Each frame uses the divisor captured at its start; a change made mid-frame
  // becomes the expected bit width of the following frame.
  task automatic test_tx_random();
    logic [FRAME-1:0] raw;
    logic [DB-1:0] b;
    bit ok;
    int d, nd;
    d = 16;
    divisor = DW'(d);
    for (int i = 0; i < 5; i++) begin
      nd = int'($urandom_range(4, 24));
      b = DB'($urandom);
      writeTx(b);
      captureTxFrame(d, 2, nd, raw, ok);
      checks++; if (!ok || raw !== frameOf(b)) begin
        failures++; $display("[TB] FAIL tx_rand_frame div=%0d got=%b ok=%0d want=%b", d, raw, ok, frameOf(b));
      end
      d = nd;
    end
    checks++; if (txBusy !== 1'b0) begin failures++; $display("[TB] FAIL tx_rand_busy_end got=%b want=0", txBusy); end
  endtask

  task automatic test_back_to_back();
    logic [DB-1:0] q[$];
    logic [DB-1:0] b;
    logic [FRAME-1:0] raw;
    bit ok, expReady;
    divisor = 16;
    fork
      begin
        for (int i = 0; i < DEPTH + 1; i++) begin
          b = DB'($urandom);
          txData = b;
          txValid = 1'b1;
          expReady = (q.size() < DEPTH);
          checks++; if (txReady !== expReady) begin
            failures++; $display("[TB] FAIL b2b_tx_ready write=%0d got=%b want=%b", i, txReady, expReady);
          end
          if (expReady) q.push_back(b);
          @(negedge clk);
        end
        txValid = 1'b0;
      end
      begin
        for (int f = 0; f < DEPTH; f++) begin
          captureTxFrame(16, (f == 0) ? 3 : 0, 16, raw, ok);
          checks++; if (!ok || raw !== frameOf(q[f])) begin
            failures++; $display("[TB] FAIL b2b_frame idx=%0d got=%b ok=%0d want=%b", f, raw, ok, frameOf(q[f]));
          end
        end
      end
    join
    checks++; if (txBusy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_busy_end got=%b want=0", txBusy); end
  endtask

  task automatic test_rx_loopback();
    int w;
    divisor = 16;
    loopback = 1'b1;
    writeTx(8'h3C);
    w = 0;
    while (rxValid !== 1'b1 && w < 400) begin
      @(negedge clk);
      w++;
    end
    checks++; if (rxValid !== 1'b1 || rxData !== 8'h3C) begin
      failures++; $display("[TB] FAIL loopback_data got=%b/%h want=1/3c", rxValid, rxData);
    end
    popRx();
    checks++; if (rxValid !== 1'b0) begin failures++; $display("[TB] FAIL loopback_pop got=%b want=0", rxValid); end
    repeat (40) @(negedge clk);
    loopback = 1'b0;
  endtask

  task automatic test_rx_glitch();
    int fe, ov, pe;
    fe = frameErrSeen; ov = overrunSeen; pe = parErrSeen;
    divisor = 16;
    rxDrive = 1'b0;
    repeat (5) @(negedge clk);
    rxDrive = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (rxValid !== 1'b0) begin failures++; $display("[TB] FAIL glitch_push got=%b want=0", rxValid); end
    checks++; if (frameErrSeen != fe || overrunSeen != ov || parErrSeen != pe) begin
      failures++; $display("[TB] FAIL glitch_errors got=%0d/%0d/%0d want=0/0/0",
                           frameErrSeen - fe, overrunSeen - ov, parErrSeen - pe);
    end
  endtask

  task automatic test_rx_frame_err();
    int fe;
    fe = frameErrSeen;
    divisor = 16;
    driveRxFrame(8'h5A, 16, 1'b0, 1'b0);
    checks++; if (frameErrSeen - fe != 1) begin
      failures++; $display("[TB] FAIL frame_err_pulse got=%0d want=1", frameErrSeen - fe);
    end
    checks++; if (rxValid !== 1'b0) begin failures++; $display("[TB] FAIL frame_err_push got=%b want=0", rxValid); end
  endtask

  task automatic test_rx_overrun();
    logic [DB-1:0] q[$];
    logic [DB-1:0] b;
    int d, ov, expOv;
    d = int'($urandom_range(4, 20));
    divisor = DW'(d);
    ov = overrunSeen;
    expOv = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = DB'($urandom);
      driveRxFrame(b, d, 1'b1, 1'b0);
      if (q.size() < DEPTH) q.push_back(b);
      else expOv++;
    end
    checks++; if (overrunSeen - ov != expOv) begin
      failures++; $display("[TB] FAIL overrun_pulses got=%0d want=%0d", overrunSeen - ov, expOv);
    end
    while (q.size() > 0) begin
      checks++; if (rxValid !== 1'b1 || rxData !== q[0]) begin
        failures++; $display("[TB] FAIL overrun_drain got=%b/%h want=1/%h", rxValid, rxData, q[0]);
      end
      popRx();
      void'(q.pop_front());
    end
    checks++; if (rxValid !== 1'b0) begin failures++; $display("[TB] FAIL overrun_empty got=%b want=0", rxValid); end
  endtask

  task automatic test_rx_random();
    logic [DB-1:0] q[$];
    logic [DB-1:0] b;
    logic stopOk;
    int d, fe, ov, pe, expFe, expOv;
    d = int'($urandom_range(4, 20));
    divisor = DW'(d);
    fe = frameErrSeen; ov = overrunSeen; pe = parErrSeen;
    expFe = 0; expOv = 0;
    for (int i = 0; i < 12; i++) begin
      if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
        checks++; if (rxValid !== 1'b1 || rxData !== q[0]) begin
          failures++; $display("[TB] FAIL rx_rand_pop got=%b/%h want=1/%h", rxValid, rxData, q[0]);
        end
        popRx();
        void'(q.pop_front());
      end
      b = DB'($urandom);
      stopOk = ($urandom_range(0, 3) != 0);
      driveRxFrame(b, d, stopOk, 1'b0);
      if (!stopOk) expFe++;
      else if (q.size() < DEPTH) q.push_back(b);
      else expOv++;
    end
    checks++; if (frameErrSeen - fe != expFe || overrunSeen - ov != expOv || parErrSeen != pe) begin
      failures++; $display("[TB] FAIL rx_rand_errors got=%0d/%0d/%0d want=%0d/%0d/0",
                           frameErrSeen - fe, overrunSeen - ov, parErrSeen - pe, expFe, expOv);
    end
    while (q.size() > 0) begin
      checks++; if (rxValid !== 1'b1 || rxData !== q[0]) begin
        failures++; $display("[TB] FAIL rx_rand_drain got=%b/%h want=1/%h", rxValid, rxData, q[0]);
      end
      popRx();
      void'(q.pop_front());
    end
    checks++; if (rxValid !== 1'b0) begin failures++; $display("[TB] FAIL rx_rand_empty got=%b want=0", rxValid); end
  endtask

`ifdef UART_BUFFERED_PARITY_EN
  task automatic test_parity();
    logic [FRAME-1:0] raw;
    bit ok;
    int pe, fe;
    divisor = 16;
    writeTx(8'h07);
    captureTxFrame(16, 2, 16, raw, ok);
    checks++; if (!ok || raw[DB+1] !== 1'b1) begin
      failures++; $display("[TB] FAIL parity_tx_bit got=%b ok=%0d want=1", raw[DB+1], ok);
    end
    pe = parErrSeen; fe = frameErrSeen;
    driveRxFrame(8'h96, 16, 1'b1, 1'b1);
    checks++; if (parErrSeen - pe != 1 || frameErrSeen != fe) begin
      failures++; $display("[TB] FAIL parity_rx_err got=%0d/%0d want=1/0", parErrSeen - pe, frameErrSeen - fe);
    end
    checks++; if (rxValid !== 1'b0) begin failures++; $display("[TB] FAIL parity_rx_push got=%b want=0", rxValid); end
  endtask
`endif

  task automatic test_reset_abort();
    divisor = 16;
    writeTx(8'h00);
    repeat (30) @(negedge clk);
    checks++; if (txLine !== 1'b0) begin failures++; $display("[TB] FAIL abort_midframe got=%b want=0", txLine); end
    #2 nrst = 1'b0;
    #1;
    checks++; if (txLine !== 1'b1 || txBusy !== 1'b0 || txReady !== 1'b1) begin
      failures++; $display("[TB] FAIL abort_tx_state got=%b%b%b want=101", txLine, txBusy, txReady);
    end
    @(negedge clk);
    nrst = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (txLine !== 1'b1 || txBusy !== 1'b0) begin
      failures++; $display("[TB] FAIL abort_after_release got=%b%b want=10", txLine, txBusy);
    end
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_tx_random();
    test_back_to_back();
    test_rx_loopback();
    test_rx_glitch();
    test_rx_frame_err();
    test_rx_overrun();
    test_rx_random();
`ifdef UART_BUFFERED_PARITY_EN
    test_parity();
`endif
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_buffered.md
UART_BUFFERED -- requirements
Module: uart_buffered

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (legal 5..8).
REQ-002 SHALL have parameter DIV_W, default 16, meaning width of the runtime baud divisor.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, meaning entries per TX and RX FIFO (power of two, at least 2).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-005 SHALL have port nrst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port divisor  input  DIV_W  clk cycles per bit (legal at least 4).
REQ-007 SHALL have port tx_data  input  DATA_BITS  byte to transmit.
REQ-008 SHALL have port tx_valid  input  1  tx_data is valid.
REQ-009 SHALL have port tx_ready  output  1  TX FIFO not full.
REQ-010 SHALL have port tx  output  1  serial line out, idle high.
REQ-011 SHALL have port tx_busy  output  1  TX FIFO non-empty or a frame is in progress.
REQ-012 SHALL have port rx  input  1  serial line in, asynchronous.
REQ-013 SHALL have port rx_data  output  DATA_BITS  head of RX FIFO.
REQ-014 SHALL have port rx_valid  output  1  RX FIFO not empty.
REQ-015 SHALL have port rx_ready  input  1  consumer pops on rx_valid and rx_ready.
REQ-016 SHALL have port rx_frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-017 SHALL have port rx_overrun  output  1  one-cycle pulse when a good frame is dropped because the RX FIFO is full.
REQ-018 SHALL have port rx_parity_err  output  1  one-cycle pulse on a parity mismatch.

Function
REQ-019 SHALL push into the TX FIFO on any cycle with tx_valid and tx_ready high; a write while full is ignored.
REQ-020 SHALL run the TX FSM through IDLE, START, DATA, PARITY (macro only) and STOP, returning to IDLE after STOP.
REQ-021 SHALL keep each TX bit on tx for exactly divisor clk cycles: start=0, data LSB first, stop=1.
REQ-022 SHALL drive the start bit no later than 2 cycles after a write to an empty TX FIFO while IDLE.
REQ-023 SHALL start the next queued frame directly after STOP, with no idle gap.
REQ-024 SHALL capture divisor at each frame start (TX and RX independently); a divisor change mid-frame takes effect on the next frame.
REQ-025 SHALL synchronise rx through 2 flops; all RX decisions use the synchronised value.
REQ-026 SHALL run the RX FSM through IDLE, START, DATA, PARITY (macro only) and STOP.
REQ-027 SHALL leave IDLE only on a synchronised 1-to-0 transition.
REQ-028 SHALL, in START, sample the line floor(divisor/2) cycles after the edge; if it reads 1 the start is false, go to IDLE, no error.
REQ-029 SHALL sample every later RX bit divisor cycles after the previous sample point.
REQ-030 SHALL, on a stop sample of 0, pulse rx_frame_err, discard the byte, return to IDLE and require a high-then-low edge before the next start.
REQ-031 SHALL, on a stop sample of 1 with no error, push the byte into the RX FIFO.
REQ-032 SHALL, when the RX FIFO is full and not popped in that cycle, drop the byte, pulse rx_overrun and keep FIFO contents unchanged.
REQ-033 SHALL accept a push and a pop in the same cycle, even when full: level is unchanged and no overrun occurs.
REQ-034 SHALL make the RX FIFO first-word-fall-through: rx_data is valid whenever rx_valid is high, and is visible 1 cycle after the push.
REQ-035 SHALL wrap FIFO pointers modulo FIFO_DEPTH and use an extra pointer bit to tell full from empty.

Reset
REQ-036 SHALL, while nrst is low, empty both FIFOs, put both FSMs in IDLE and drive tx=1, tx_ready=1, tx_busy=0, rx_valid=0, rx_data=0 and all error pulses=0.
REQ-037 SHALL abort a frame in progress at reset assertion: tx goes high immediately and a partial RX byte is discarded.
REQ-038 SHALL make reset release take effect on the first clk edge with nrst high; the RX sync flops reset to 1.

Configuration
REQ-039 SHALL, with macro UART_BUFFERED_PARITY_EN defined, send an even-parity bit after the data on TX and check it on RX; a mismatch pulses rx_parity_err and drops the byte, while stop checking still applies.
REQ-040 SHALL, without UART_BUFFERED_PARITY_EN, have no PARITY state, frames of 1+DATA_BITS+1 bits, and rx_parity_err tied to 0.

Verification
REQ-041 SHALL cover: divisor=16, write 0xA5 -> tx reads 0, 1,0,1,0,0,1,0,1, 1, each bit held 16 cycles; tx_busy drops after 160 cycles.
REQ-042 SHALL cover: FIFO_DEPTH=4, write 5 bytes back-to-back -> tx_ready low after 4 accepted, the 5th is ignored, 4 frames sent with no gap.
REQ-043 SHALL cover: rx loopback of 0x3C at divisor=16 -> rx_valid high with rx_data=0x3C; a pop then drives rx_valid to 0.
REQ-044 SHALL cover: a 5-cycle low glitch on rx at divisor=16 -> no push and no error pulse.
REQ-045 SHALL cover: stop bit forced 0 -> rx_frame_err pulses 1 cycle and the FIFO is unchanged; with FIFO full and 5 frames received with no pop -> one rx_overrun pulse.
REQ-046 SHALL cover: with parity enabled, 0x07 sends parity 1; an injected flipped parity on RX -> rx_parity_err pulse and no push.
